dff_bank_arbiter: RTL and testbench

Two-requester arbiter and sequencer for a shared WIDTH-bit D-flip-flop storage bank.
- Grants the bank to one requester at a time using round-robin priority.
- Holds the grant for HOLD cycles, then captures that requester's data into the bank and acknowledges.
- Sits between lab stimulus sources and the DFF datapath, so several drivers can share one register without contention.

---
 rtl/dff_bank_arbiter_pkg.sv | 15 +
 rtl/dff_reg.sv | 26 ++
 rtl/dff_bank_arbiter.sv | 111 +++++++++++
 tb/tb_dff_bank_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the two-requester DFF bank arbiter:
// state encodings and hold-counter width.
package dff_bank_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT0 = 3'd1,
    GRANT1 = 3'd2,
    ACK0S  = 3'd3,
    ACK1S  = 3'd4
  } state_e;

endpackage

// File: rtl/dff_reg.sv
// WIDTH-bit register bank with load enable; reset wins over load.
module dff_reg #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (EN) q_d = D;
  end

  always_ff @(posedge CLK) begin
    if (RST) q_q <= '0;
    else     q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that grants a shared register bank for HOLD cycles,
// captures the winner's data at the end of the grant and pulses an ack.
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int HOLD  = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] D0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             ACK0,
  output logic             ACK1,
  output logic [WIDTH-1:0] Q,
  output logic             OWNER,
  output logic             BUSY
);

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             pri_d, pri_q;
  logic             owner_d, owner_q;
  logic             cap_en;
  logic [WIDTH-1:0] cap_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pri_d   = pri_q;
    owner_d = owner_q;
    cap_en  = 1'b0;
    case (state_q)
      IDLE: begin
        // Requester 0 wins when alone or when it holds priority.
        if (REQ0 && (!REQ1 || !pri_q)) begin
          state_d = GRANT0;
          cnt_d   = HOLD_M1;
        end else if (REQ1) begin
          state_d = GRANT1;
          cnt_d   = HOLD_M1;
        end
      end
      GRANT0: begin
        if (!REQ0) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          cap_en  = 1'b1;
          owner_d = 1'b0;
          pri_d   = 1'b1;
          state_d = ACK0S;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GRANT1: begin
        if (!REQ1) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          cap_en  = 1'b1;
          owner_d = 1'b1;
          pri_d   = 1'b0;
          state_d = ACK1S;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK0S, ACK1S: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pri_q   <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pri_q   <= pri_d;
      owner_q <= owner_d;
    end
  end

  assign cap_data = (state_q == GRANT1) ? D1 : D0;

  dff_reg #(.WIDTH(WIDTH)) u_bank (
    .CLK (CLK),
    .RST (RST),
    .EN  (cap_en),
    .D   (cap_data),
    .Q   (Q)
  );

  // Outputs decode the registered state only, so REQ never reaches GNT combinationally.
  assign GNT0  = (state_q == GRANT0);
  assign GNT1  = (state_q == GRANT1);
  assign ACK0  = (state_q == ACK0S);
  assign ACK1  = (state_q == ACK1S);
  assign BUSY  = (state_q != IDLE);
  assign OWNER = owner_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench: three arbiters (HOLD=1,2,3) share CLK/RST; expected acks
// and grant lengths are queued by the stimulus and checked by a monitor.
module tb_dff_bank_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]       req0, req1, gnt0, gnt1, ack0, ack1, owner, busy;
  logic [2:0][3:0]  d0, d1, q;

  always #5 clk = ~clk;

  dff_bank_arbiter #(.WIDTH(4), .HOLD(1)) u_h1 (
    .CLK(clk), .RST(rst), .REQ0(req0[0]), .D0(d0[0]), .REQ1(req1[0]), .D1(d1[0]),
    .GNT0(gnt0[0]), .GNT1(gnt1[0]), .ACK0(ack0[0]), .ACK1(ack1[0]),
    .Q(q[0]), .OWNER(owner[0]), .BUSY(busy[0]));

  dff_bank_arbiter #(.WIDTH(4), .HOLD(2)) u_h2 (
    .CLK(clk), .RST(rst), .REQ0(req0[1]), .D0(d0[1]), .REQ1(req1[1]), .D1(d1[1]),
    .GNT0(gnt0[1]), .GNT1(gnt1[1]), .ACK0(ack0[1]), .ACK1(ack1[1]),
    .Q(q[1]), .OWNER(owner[1]), .BUSY(busy[1]));

  dff_bank_arbiter #(.WIDTH(4), .HOLD(3)) u_h3 (
    .CLK(clk), .RST(rst), .REQ0(req0[2]), .D0(d0[2]), .REQ1(req1[2]), .D1(d1[2]),
    .GNT0(gnt0[2]), .GNT1(gnt1[2]), .ACK0(ack0[2]), .ACK1(ack1[2]),
    .Q(q[2]), .OWNER(owner[2]), .BUSY(busy[2]));

  typedef struct {int dut; logic who; logic [3:0] qv; logic own;} ack_t;
  typedef struct {int dut; logic who; int len;} gnt_t;

  ack_t ack_q[$];
  gnt_t gnt_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic started = 1'b0;
  int   gcnt[3];
  logic gwho[3];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ack(int k, logic w, logic [3:0] v, logic o);
    ack_t a;
    a.dut = k; a.who = w; a.qv = v; a.own = o;
    ack_q.push_back(a);
  endtask

  task automatic push_gnt(int k, logic w, int len);
    gnt_t g;
    g.dut = k; g.who = w; g.len = len;
    gnt_q.push_back(g);
  endtask

  task automatic wait_acks(int k, int n, int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      tick();
      if (ack0[k] | ack1[k]) seen++;
    end
    if (seen < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: dut %0d saw %0d acks, required %0d", k, seen, n);
    end
  endtask

  // Monitor: exclusivity every cycle, ack contents and grant run lengths.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk("exclusive", {30'd0, gnt0[k] & gnt1[k], ack0[k] & ack1[k]}, 32'd0);
        if (ack0[k] | ack1[k]) begin
          if (ack_q.size() == 0) fail("unexpected_ack");
          else begin
            ack_t a;
            a = ack_q.pop_front();
            chk("ack_dut", k, a.dut);
            chk("ack_who", {31'd0, ack1[k]}, {31'd0, a.who});
            chk("ack_q", {28'd0, q[k]}, {28'd0, a.qv});
            chk("ack_owner", {31'd0, owner[k]}, {31'd0, a.own});
          end
        end
        if (gnt0[k] | gnt1[k]) begin
          if (gcnt[k] == 0) gwho[k] = gnt1[k];
          gcnt[k]++;
        end else if (gcnt[k] > 0) begin
          if (gnt_q.size() == 0) fail("unexpected_gnt");
          else begin
            gnt_t g;
            g = gnt_q.pop_front();
            chk("gnt_dut", k, g.dut);
            chk("gnt_who", {31'd0, gwho[k]}, {31'd0, g.who});
            chk("gnt_len", gcnt[k], g.len);
          end
          gcnt[k] = 0;
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) gcnt[k] = 0;
    rst = 1'b1;
    req0 = '0; req1 = '0; d0 = '0; d1 = '0;
    // Reset with both requests high on the HOLD=2 instance.
    req0[1] = 1'b1; req1[1] = 1'b1; d0[1] = 4'h3; d1[1] = 4'hC;
    tick();
    started = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_q", {28'd0, q[k]}, 32'd0);
      chk("rst_outs", {26'd0, gnt0[k], gnt1[k], ack0[k], ack1[k], busy[k], owner[k]}, 32'd0);
    end

    // Contention: alternation 0,1,0,1 starting with requester 0.
    for (int i = 0; i < 2; i++) begin
      push_gnt(1, 1'b0, 2); push_ack(1, 1'b0, 4'h3, 1'b0);
      push_gnt(1, 1'b1, 2); push_ack(1, 1'b1, 4'hC, 1'b1);
    end
    rst = 1'b0;
    wait_acks(1, 4, 40);
    req0[1] = 1'b0; req1[1] = 1'b0;
    tick();
    tick();

    // Single write, HOLD=2.
    push_gnt(1, 1'b0, 2); push_ack(1, 1'b0, 4'hA, 1'b0);
    req0[1] = 1'b1; d0[1] = 4'hA;
    wait_acks(1, 1, 20);
    req0[1] = 1'b0;
    tick();
    chk("single_busy", {31'd0, busy[1]}, 32'd0);
    chk("single_q", {28'd0, q[1]}, 32'hA);
    chk("single_owner", {31'd0, owner[1]}, 32'd0);

    // HOLD=3: prior write of 6, then abort a requester-1 grant after one cycle.
    push_gnt(2, 1'b0, 3); push_ack(2, 1'b0, 4'h6, 1'b0);
    req0[2] = 1'b1; d0[2] = 4'h6;
    wait_acks(2, 1, 20);
    req0[2] = 1'b0;
    tick();
    push_gnt(2, 1'b1, 1);
    req1[2] = 1'b1; d1[2] = 4'h7;
    tick();
    req1[2] = 1'b0;
    tick();
    chk("abort_busy", {31'd0, busy[2]}, 32'd0);
    chk("abort_q", {28'd0, q[2]}, 32'h6);
    chk("abort_owner", {31'd0, owner[2]}, 32'd0);
    // Priority still favours requester 1 after the abort.
    push_gnt(2, 1'b1, 3); push_ack(2, 1'b1, 4'h2, 1'b1);
    req0[2] = 1'b1; d0[2] = 4'h1; req1[2] = 1'b1; d1[2] = 4'h2;
    wait_acks(2, 1, 20);
    req0[2] = 1'b0; req1[2] = 1'b0;
    tick();

    // Reset in the middle of a grant.
    push_gnt(2, 1'b0, 3); push_ack(2, 1'b0, 4'h5, 1'b0);
    req0[2] = 1'b1; d0[2] = 4'h5;
    wait_acks(2, 1, 20);
    req0[2] = 1'b0;
    tick();
    chk("pre_rst_q", {28'd0, q[2]}, 32'h5);
    push_gnt(2, 1'b0, 1);
    req0[2] = 1'b1; d0[2] = 4'hF;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_q", {28'd0, q[2]}, 32'd0);
    chk("midrst_outs", {29'd0, gnt0[2], ack0[2], busy[2]}, 32'd0);
    rst = 1'b0; req0[2] = 1'b0;
    tick();
    tick();

    // HOLD=1 boundary.
    push_gnt(0, 1'b1, 1); push_ack(0, 1'b1, 4'h9, 1'b1);
    req1[0] = 1'b1; d1[0] = 4'h9;
    wait_acks(0, 1, 10);
    req1[0] = 1'b0;
    tick();
    chk("h1_q", {28'd0, q[0]}, 32'h9);
    chk("h1_owner", {31'd0, owner[0]}, 32'd1);

    repeat (3) tick();
    chk("ack_q_drained", ack_q.size(), 32'd0);
    chk("gnt_q_drained", gnt_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
